// File: rtl/load_use_scoreboard_pkg.sv
// Shared defaults and sizing helpers for the load-use hazard scoreboard.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF   = 5;
  localparam int LOAD_LATENCY_DEF = 1;
  localparam int CNT_W_DEF        = 16;

  // Countdown width: wide enough to hold LOAD_LATENCY itself.
  function automatic int cnt_width(input int load_latency);
    return (load_latency < 1) ? 1 : $clog2(load_latency + 1);
  endfunction

endpackage

// File: rtl/load_use_scoreboard_if.sv
// ID-stage hazard bus: instruction fields and stall/flush results.
interface load_use_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic                  id_mem_read;
  logic                  mdu_busy;
  logic                  ex_redirect;
  logic                  stall;
  logic                  flush_if_id;
  logic                  flush_id_ex;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_mem_read, mdu_busy, ex_redirect,
    input  stall, flush_if_id, flush_id_ex, stall_count
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_mem_read, mdu_busy, ex_redirect,
    output stall, flush_if_id, flush_id_ex, stall_count
  );
endinterface

// File: rtl/load_use_scoreboard_reg_scoreboard.sv
// Per-register load countdown array with two combinational busy lookups.
module reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int ADDR_W       = REG_ADDR_W_DEF,
  parameter int LOAD_LATENCY = LOAD_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_set,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic              o_busy_a,
  output logic              o_busy_b
);
  localparam int CW    = cnt_width(LOAD_LATENCY);
  localparam int DEPTH = 1 << ADDR_W;

  logic [CW-1:0]    r_cnt [DEPTH];
  logic [DEPTH-1:0] w_busy;

  // A fresh load reload wins over the ongoing decrement of the same entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        r_cnt[i] <= '0;
      end else if (i_set && (i_set_addr == ADDR_W'(i))) begin
        r_cnt[i] <= CW'(LOAD_LATENCY);
      end else if (r_cnt[i] != '0) begin
        r_cnt[i] <= r_cnt[i] - CW'(1);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign w_busy[gi] = 1'b0;
      end else begin : g_reg
        assign w_busy[gi] = (r_cnt[gi] != '0);
      end
    end
  endgenerate

  assign o_busy_a = w_busy[i_rd_addr_a];
  assign o_busy_b = w_busy[i_rd_addr_b];
endmodule

// File: rtl/load_use_scoreboard.sv
// ID/EX hazard unit: load-use scoreboard stalls, MDU stall, redirect flushes.
module load_use_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int LOAD_LATENCY = LOAD_LATENCY_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  load_use_scoreboard_if.slave  bus
);
  logic             w_rs1_busy;
  logic             w_rs2_busy;
  logic             w_data_hz;
  logic             w_stall;
  logic             w_issue;
  logic             w_set;
  logic [CNT_W-1:0] r_stall_count;

  reg_scoreboard #(
    .ADDR_W       (REG_ADDR_W),
    .LOAD_LATENCY (LOAD_LATENCY)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_set       (w_set),
    .i_set_addr  (bus.id_rd_addr),
    .i_rd_addr_a (bus.id_rs1_addr),
    .i_rd_addr_b (bus.id_rs2_addr),
    .o_busy_a    (w_rs1_busy),
    .o_busy_b    (w_rs2_busy)
  );

  assign w_data_hz = bus.id_valid & ((bus.id_rs1_used & w_rs1_busy) |
                                     (bus.id_rs2_used & w_rs2_busy));

  // A redirect discards the ID instruction, so it must never be held.
  assign w_stall = ~bus.ex_redirect & (w_data_hz | (bus.id_valid & bus.mdu_busy));
  assign w_issue = bus.id_valid & ~w_stall & ~bus.ex_redirect;
  assign w_set   = w_issue & bus.id_mem_read & (bus.id_rd_addr != '0);

  assign bus.stall       = w_stall;
  assign bus.flush_if_id = bus.ex_redirect;
  assign bus.flush_id_ex = bus.ex_redirect | w_stall;
  assign bus.stall_count = r_stall_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_load_use_scoreboard.sv
// Drives three configurations (LL=1/CNT16, LL=3/CNT16, LL=3/CNT2) with shared directed stimulus.
module tb_load_use_scoreboard;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       id_valid = 1'b0;
  logic [4:0] id_rs1_addr = '0;
  logic [4:0] id_rs2_addr = '0;
  logic       id_rs1_used = 1'b0;
  logic       id_rs2_used = 1'b0;
  logic [4:0] id_rd_addr = '0;
  logic       id_mem_read = 1'b0;
  logic       mdu_busy = 1'b0;
  logic       ex_redirect = 1'b0;

  logic [NI-1:0] st;
  logic [NI-1:0] fii;
  logic [NI-1:0] fie;
  logic [15:0]   sc [NI];

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int LL = (gi == 0) ? 1 : 3;
      localparam int CW = (gi == 2) ? 2 : 16;
      load_use_scoreboard_if #(.REG_ADDR_W(5), .CNT_W(CW)) bus ();
      assign bus.id_valid    = id_valid;
      assign bus.id_rs1_addr = id_rs1_addr;
      assign bus.id_rs2_addr = id_rs2_addr;
      assign bus.id_rs1_used = id_rs1_used;
      assign bus.id_rs2_used = id_rs2_used;
      assign bus.id_rd_addr  = id_rd_addr;
      assign bus.id_mem_read = id_mem_read;
      assign bus.mdu_busy    = mdu_busy;
      assign bus.ex_redirect = ex_redirect;
      assign st[gi]  = bus.stall;
      assign fii[gi] = bus.flush_if_id;
      assign fie[gi] = bus.flush_id_ex;
      assign sc[gi]  = 16'(bus.stall_count);
      load_use_scoreboard #(.REG_ADDR_W(5), .LOAD_LATENCY(LL), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );
    end
  endgenerate

  // Model: each register remembers the first cycle its load result is usable.
  int ll_tab  [NI] = '{1, 3, 3};
  int max_tab [NI] = '{65535, 65535, 3};
  int ready   [NI][32];
  int m_cnt   [NI];
  int cyc = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic bit m_busy(input int i, input int r);
    return (r != 0) && (ready[i][r] > cyc);
  endfunction

  function automatic bit m_stall(input int i);
    bit hz;
    hz = id_valid && ((id_rs1_used && m_busy(i, int'(id_rs1_addr))) ||
                      (id_rs2_used && m_busy(i, int'(id_rs2_addr))));
    return !ex_redirect && (hz || (id_valid && mdu_busy));
  endfunction

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cyc=%0d: got %0d, expected %0d", nm, inst, cyc, act, exp);
    end
  endtask

  // Per-cycle compare at negedge, then model update at the following posedge.
  task automatic step();
    bit s;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      s = m_stall(i);
      chk("stall", i, int'(st[i]), int'(s));
      chk("flush_if_id", i, int'(fii[i]), int'(ex_redirect));
      chk("flush_id_ex", i, int'(fie[i]), int'(ex_redirect || s));
      chk("stall_count", i, int'(sc[i]), m_cnt[i]);
    end
    $display("cyc %0d rst=%0b v=%0b rs1=%0d/%0b rs2=%0d/%0b rd=%0d ld=%0b mdu=%0b redir=%0b stall=%b cnt=%0d/%0d/%0d",
             cyc, rst, id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
             id_rd_addr, id_mem_read, mdu_busy, ex_redirect, st, sc[0], sc[1], sc[2]);
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_cnt[i] = 0;
        for (int r = 0; r < 32; r++) ready[i][r] = 0;
      end else begin
        s = m_stall(i);
        if (s && m_cnt[i] < max_tab[i]) m_cnt[i]++;
        if (id_valid && !s && !ex_redirect && id_mem_read && id_rd_addr != 0)
          ready[i][id_rd_addr] = cyc + ll_tab[i] + 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit ld, input bit mdu, input bit redir, input bit r);
    id_valid    = v;
    id_rs1_addr = 5'(rs1);
    id_rs1_used = u1;
    id_rs2_addr = 5'(rs2);
    id_rs2_used = u2;
    id_rd_addr  = 5'(rd);
    id_mem_read = ld;
    mdu_busy    = mdu;
    ex_redirect = redir;
    rst         = r;
    #1;
  endtask

  task automatic nop(input int n);
    for (int k = 0; k < n; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = 0;
      for (int r = 0; r < 32; r++) ready[i][r] = 0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NI; i++) begin
      chk("lit_reset_stall", i, int'(st[i]), 0);
      chk("lit_reset_count", i, int'(sc[i]), 0);
    end
    step();

    // A: load x5 then add x6,x5,x7 held for 4 cycles
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step();
    drive(1, 5, 1, 7, 1, 6, 0, 0, 0, 0);
    chk("lit_A_stall", 0, int'(st[0]), 1);
    chk("lit_A_flush_id_ex", 0, int'(fie[0]), 1);
    step();
    drive(1, 5, 1, 7, 1, 6, 0, 0, 0, 0);
    chk("lit_A_issue", 0, int'(st[0]), 0);
    step();
    repeat (2) begin drive(1, 5, 1, 7, 1, 6, 0, 0, 0, 0); step(); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_A_count", 0, int'(sc[0]), 1);
    chk("lit_A_count", 1, int'(sc[1]), 3);
    step();
    nop(3);

    // B: load x5, independent, then use of x5
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step();
    drive(1, 1, 1, 2, 1, 8, 0, 0, 0, 0); step();
    drive(1, 5, 1, 0, 0, 9, 0, 0, 0, 0);
    chk("lit_B_stall1", 1, int'(st[1]), 1);
    chk("lit_B_nostall", 0, int'(st[0]), 0);
    step();
    drive(1, 5, 1, 0, 0, 9, 0, 0, 0, 0);
    chk("lit_B_stall2", 1, int'(st[1]), 1);
    step();
    drive(1, 5, 1, 0, 0, 9, 0, 0, 0, 0);
    chk("lit_B_issue", 1, int'(st[1]), 0);
    step();
    nop(4);

    // C: x0 never busy; unused source never stalls
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    drive(1, 0, 1, 0, 1, 4, 0, 0, 0, 0);
    for (int i = 0; i < NI; i++) chk("lit_C_x0", i, int'(st[i]), 0);
    step();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step();
    drive(1, 5, 0, 3, 1, 4, 0, 0, 0, 0);
    for (int i = 0; i < NI; i++) chk("lit_C_unused", i, int'(st[i]), 0);
    step();
    nop(4);

    // D: redirect overrides a pending stall; a killed load marks nothing
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); step();
    drive(1, 9, 1, 0, 0, 4, 0, 0, 1, 0);
    for (int i = 0; i < NI; i++) begin
      chk("lit_D_stall", i, int'(st[i]), 0);
      chk("lit_D_flush_if_id", i, int'(fii[i]), 1);
      chk("lit_D_flush_id_ex", i, int'(fie[i]), 1);
    end
    step();
    drive(1, 0, 0, 0, 0, 10, 1, 0, 1, 0); step();
    drive(1, 10, 1, 9, 0, 4, 0, 0, 0, 0);
    for (int i = 0; i < NI; i++) chk("lit_D_killed_load", i, int'(st[i]), 0);
    step();
    nop(4);

    // E: MDU busy for 4 cycles
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, 2, 0, 3, 0, 1, 0, 0);
      chk("lit_E_mdu", 0, int'(st[0]), 1);
      step();
    end
    drive(1, 1, 0, 2, 0, 3, 0, 0, 0, 0);
    chk("lit_E_release", 0, int'(st[0]), 0);
    step();

    // F: reset mid-countdown
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step();
    drive(1, 5, 1, 0, 0, 6, 0, 0, 0, 1); step();
    drive(1, 5, 1, 0, 0, 6, 0, 0, 0, 0);
    for (int i = 0; i < NI; i++) begin
      chk("lit_F_stall", i, int'(st[i]), 0);
      chk("lit_F_count", i, int'(sc[i]), 0);
    end
    step();

    // G: 5 stall cycles saturate a 2-bit counter
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 0, 0, 3, 0, 1, 0, 0); step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_G_sat", 2, int'(sc[2]), 3);
    chk("lit_G_count", 0, int'(sc[0]), 5);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
